// File: rtl/spi_master_param_pkg.sv
// Shared types and mode encodings for the parametrised SPI master.
package spi_master_param_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  // {cpol, cpha} encodings of the four SPI modes
  localparam logic [1:0] MODE_0 = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;
  localparam logic [1:0] MODE_2 = 2'b10;
  localparam logic [1:0] MODE_3 = 2'b11;

  // Modes 0 and 2 sample on the leading edge; 1 and 3 drive on it.
  function automatic logic mode_samples_on_lead(spi_mode_t m);
    return ({m.cpol, m.cpha} inside {MODE_0, MODE_2});
  endfunction

endpackage

// File: rtl/spi_master_param_clk_gen.sv
// SCLK half-period divider: tick at the end of every half-period, plus
// leading/trailing edge strobes while the shift phase is active.
module spi_master_param_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic shift_en,
  output logic tick_c,
  output logic lead_c,
  output logic trail_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             phase;

  assign tick_c  = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign lead_c  = tick_c && shift_en && !phase;
  assign trail_c = tick_c && shift_en && phase;

  // phase tracks whether sclk currently sits away from its idle level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      if (!run || tick_c) div_cnt <= '0;
      else                div_cnt <= div_cnt + DIV_W'(1);
      if (!shift_en)   phase <= 1'b0;
      else if (tick_c) phase <= ~phase;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master with configurable width, divider, mode, bit order
// and chip select; everything is latched when a transfer is accepted.
module spi_master_param
  import spi_master_param_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_CS  = 4,
  parameter int unsigned CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  spi_state_t        state;
  spi_mode_t         mode;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [CNT_W-1:0]  bit_cnt;
  logic [NUM_CS-1:0] cs_dec_c;
  logic tick_c, lead_c, trail_c;
  logic run_c, shift_en_c, sample_c, drive_c, last_c;

  function automatic logic first_bit(logic [DATA_W-1:0] w, logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(logic [DATA_W-1:0] w, logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] add_bit(logic [DATA_W-1:0] w, logic lsb, logic b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign run_c      = (state != IDLE);
  assign shift_en_c = (state == SHIFT);
  assign sample_c   = mode_samples_on_lead(mode) ? lead_c : trail_c;
  assign drive_c    = mode_samples_on_lead(mode) ? trail_c : lead_c;
  // last trailing edge: all bits sampled, or the final sample happens on it
  assign last_c     = trail_c && ((bit_cnt == CNT_W'(DATA_W)) ||
                                  (sample_c && (bit_cnt == CNT_W'(DATA_W - 1))));

  // out-of-range selects leave every line high
  always_comb begin
    cs_dec_c = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) cs_dec_c[i] = 1'b0;
    end
  end

  spi_master_param_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .run     (run_c),
    .shift_en(shift_en_c),
    .tick_c  (tick_c),
    .lead_c  (lead_c),
    .trail_c (trail_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mode    <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode    <= {cpol, cpha, lsb_first};
          cs_n    <= cs_dec_c;
          sclk    <= cpol;
          busy    <= 1'b1;
          bit_cnt <= '0;
          rx_sh   <= '0;
          // cpha=0 slaves sample on the first edge, so bit 0 goes out now
          if (cpha) begin
            tx_sh <= tx_data;
            mosi  <= 1'b0;
          end else begin
            tx_sh <= drop_bit(tx_data, lsb_first);
            mosi  <= first_bit(tx_data, lsb_first);
          end
          state <= SETUP;
        end
        SETUP: if (tick_c) state <= SHIFT;
        SHIFT: begin
          if (lead_c || trail_c) sclk <= ~sclk;
          if (sample_c) begin
            rx_sh   <= add_bit(rx_sh, mode.lsb_first, miso);
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (drive_c) begin
            mosi  <= first_bit(tx_sh, mode.lsb_first);
            tx_sh <= drop_bit(tx_sh, mode.lsb_first);
          end
          if (last_c) state <= HOLD;
        end
        HOLD: if (tick_c) begin
          cs_n    <= '1;
          rx_data <= rx_sh;
          done    <= 1'b1;
          busy    <= 1'b0;
          mosi    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
